// File: rtl/spatz_id_tracker.sv
// -----------------------------------------------------------------------------
// spatz_id_tracker
//
// Hands out instruction IDs to the Spatz controller and keeps track of which
// IDs are in flight and which execution unit (CON/LSU/SLD/VFU) owns each one.
// IDs are returned through NrRetirePorts independent retire channels.
//
// Optional feature (compile-time macro SPATZ_ID_ROUND_ROBIN_EN):
//   defined   -> a registered pointer holds (last granted ID + 1) mod NrIds and
//                the grant is the first free ID searching upward from it, with
//                wrap-around. Recently retired IDs then stay idle longer, which
//                makes traces easier to follow.
//   undefined -> the grant is always the lowest-index free ID.
//
// Handshakes:
//   alloc : an ID is granted when alloc_valid_i && alloc_ready_o are both
//           high at a rising clock edge. alloc_id_o is combinational and does
//           not depend on alloc_valid_i. alloc_ready_o does not depend on
//           retires in the same cycle (no bypass).
//   retire: each retire_valid_i[k] is a single-cycle strobe with no ready; the
//           ID on channel k is released at the next rising edge.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   alloc_valid_i     controller requests a new ID
//   alloc_ready_o     a free ID exists
//   alloc_unit_i      ex_unit_e of the instruction being issued
//   alloc_id_o        ID granted on handshake
//   retire_valid_i    per-channel retire strobe
//   retire_id_i       per-channel retiring ID, channel k at [k*IdWidth +: IdWidth]
//   busy_o            in-flight bitmap
//   unit_busy_o       bit u set when any live ID is owned by unit u
//   in_flight_cnt_o   number of live IDs
//   empty_o, full_o   no ID live / all IDs live
//   retire_err_o      sticky flag: a retire named an ID that was not live
// -----------------------------------------------------------------------------
module spatz_id_tracker #(
  parameter  int unsigned NrIds         = 4,
  parameter  int unsigned NrRetirePorts = 3,
  localparam int unsigned IdWidth       = $clog2(NrIds),
  localparam int unsigned CntWidth      = $clog2(NrIds + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               alloc_valid_i,
  output logic                               alloc_ready_o,
  input  logic [1:0]                         alloc_unit_i,
  output logic [IdWidth-1:0]                 alloc_id_o,
  input  logic [NrRetirePorts-1:0]           retire_valid_i,
  input  logic [NrRetirePorts*IdWidth-1:0]   retire_id_i,
  output logic [NrIds-1:0]                   busy_o,
  output logic [3:0]                         unit_busy_o,
  output logic [CntWidth-1:0]                in_flight_cnt_o,
  output logic                               empty_o,
  output logic                               full_o,
  output logic                               retire_err_o
);

  // Execution unit encoding shared with the controller.
  typedef enum logic [1:0] {
    UNIT_CON = 2'd0,
    UNIT_LSU = 2'd1,
    UNIT_SLD = 2'd2,
    UNIT_VFU = 2'd3
  } ex_unit_e;

  // Full range addressable by an IdWidth-bit ID. When NrIds is not a power of
  // two, the codes above NrIds-1 read as "not live" and therefore flag an error.
  localparam int unsigned IdSpace = 1 << IdWidth;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NrIds-1:0] busy_q, busy_d;
  ex_unit_e         owner_q [NrIds];
  logic             err_q, err_d;

  logic             fire;
  logic [NrIds-1:0] retire_mask;
  logic [NrIds-1:0] grant_onehot;
  logic             retire_bad;
  logic [IdSpace-1:0] busy_ext;

  assign busy_ext = IdSpace'(busy_q);

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
`ifdef SPATZ_ID_ROUND_ROBIN_EN
  logic [IdWidth-1:0] ptr_q;
  logic [IdWidth-1:0] ptr_d;
  logic [IdWidth-1:0] cand;
  logic               found;

  // First free ID at or above the pointer, wrapping around past NrIds-1.
  always_comb begin
    alloc_id_o = '0;
    found      = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < NrIds; i++) begin
      cand = IdWidth'((int unsigned'(ptr_q) + i) % NrIds);
      if (!found && !busy_ext[cand]) begin
        alloc_id_o = cand;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      ptr_d = (alloc_id_o == IdWidth'(NrIds - 1)) ? '0 : alloc_id_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Lowest-index free ID: scan downward so the lowest free index wins last.
  always_comb begin
    alloc_id_o = '0;
    for (int i = int'(NrIds) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_id_o = IdWidth'(i);
      end
    end
  end
`endif

  assign full_o        = &busy_q;
  assign empty_o       = ~|busy_q;
  assign alloc_ready_o = ~full_o;
  assign fire          = alloc_valid_i & alloc_ready_o;

  always_comb begin
    grant_onehot = '0;
    for (int unsigned j = 0; j < NrIds; j++) begin
      if (fire && (alloc_id_o == IdWidth'(j))) begin
        grant_onehot[j] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Retire decode. Several channels naming the same ID simply OR into the mask,
  // so a live ID is released once and does not count as an error.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [IdWidth-1:0] rid;
    retire_mask = '0;
    retire_bad  = 1'b0;
    rid         = '0;
    for (int unsigned k = 0; k < NrRetirePorts; k++) begin
      rid = retire_id_i[k*IdWidth +: IdWidth];
      if (retire_valid_i[k]) begin
        if (!busy_ext[rid]) begin
          retire_bad = 1'b1;
        end
        for (int unsigned j = 0; j < NrIds; j++) begin
          if (rid == IdWidth'(j)) begin
            retire_mask[j] = 1'b1;
          end
        end
      end
    end
  end

  // The grant always targets a free ID, so clearing before setting only matters
  // when a bogus retire names the very ID being granted: the grant wins.
  assign busy_d = (busy_q & ~retire_mask) | grant_onehot;
  assign err_d  = err_q | retire_bad;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < NrIds; i++) begin
        owner_q[i] <= UNIT_CON;
      end
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
      // Owner entries of retired IDs are left stale; busy masks them.
      for (int unsigned i = 0; i < NrIds; i++) begin
        if (grant_onehot[i]) begin
          owner_q[i] <= ex_unit_e'(alloc_unit_i);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Derived status, all straight from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    unit_busy_o = '0;
    for (int unsigned i = 0; i < NrIds; i++) begin
      if (busy_q[i]) begin
        unit_busy_o[owner_q[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    in_flight_cnt_o = '0;
    for (int unsigned i = 0; i < NrIds; i++) begin
      in_flight_cnt_o = in_flight_cnt_o + CntWidth'(busy_q[i]);
    end
  end

  assign busy_o       = busy_q;
  assign retire_err_o = err_q;

endmodule
